arb16_rr: RTL
=============

Name: arb16_rr

Overview:
- 16-requester round-robin arbiter that shares one W-bit output channel.
- Selects one requester, drives the 4-bit mux select and the one-hot grant, and holds the grant for a multi-beat packet until the beat marked last transfers.
- Data steering uses the team's existing 16:1 mux tree, instantiated internally with sel from the arbiter state.
- Sits between per-source request queues and a single shared consumer (e.g. a bus or writeback port).

Parameters:
- W, 32, data width per requester and on the output.
- MAX_BEATS, 16, beat limit per grant; used only when ARB16_MAXBEAT_EN is defined; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- req  input  16  per-requester valid; bit i means requester i presents a beat.
- last  input  16  per-requester end-of-packet flag, qualified by req[i].
- in_data  input  16*W  requester data; slice i is in_data[i*W +: W].
- in_ready  output  16  per-requester ready; in_ready[i] = grant[i] & out_ready.
- out_valid  output  1  output beat valid.
- out_data  output  W  muxed data of the granted requester.
- out_last  output  1  muxed last of the granted requester.
- out_ready  input  1  consumer accepts the beat.
- grant  output  16  one-hot registered grant, all-zero when idle.
- sel  output  4  registered encoded index of the granted requester.
- err  output  1  forced-release pulse; tied 0 unless ARB16_MAXBEAT_EN is defined.

Behaviour:
- State machine has two states: IDLE and BUSY. Registered state: state, sel, grant, ptr (4-bit round-robin pointer), and a beat counter when the option is enabled.
- Reset (rst==0 at an edge) sets:
  - state=IDLE, grant=0, sel=0, ptr=0, err=0.
  - Reset takes priority over everything, including mid-packet; the in-flight packet is abandoned and no partial state is kept.
- IDLE:
  - out_valid=0, in_ready=0.
  - If req != 0, choose the first index k scanning ptr, ptr+1, ... ptr+15 (mod 16) with req[k]=1.
  - Next edge: sel<=k, grant<=one-hot(k), state<=BUSY.
  - If req == 0, remain in IDLE.
  - A new grant therefore costs exactly one idle cycle (arbitration bubble).
- BUSY:
  - out_valid = req[sel]; out_data = in_data slice sel; out_last = last[sel] & req[sel].
  - A beat transfers when out_valid & out_ready.
  - A transfer with out_last=1 causes, at the next edge: state<=IDLE, grant<=0, ptr<=sel+1 (4-bit wrap: 15 -> 0). sel keeps its value.
  - Transfers without last keep the grant.
  - If the granted requester deasserts req mid-packet, the grant is held and out_valid=0. There is no timeout unless the option is enabled.
  - Requests from other indices during BUSY are ignored; they are considered at the next IDLE.
- Outputs are combinational from registered sel/grant and the live inputs: zero-cycle latency from req/in_data to out_*. No combinational path from out_ready to out_valid.
- Fairness: after requester k finishes, k has the lowest priority in the next arbitration. With all 16 requesting single-beat packets, grant order is 0,1,...,15,0,...
- Single requester: repeated packets alternate BUSY/IDLE, so one packet completes every (beats+1) cycles at full out_ready.

Optional Feature:
- Macro: ARB16_MAXBEAT_EN.
- Defined:
  - A beat counter (width clog2(MAX_BEATS+1)) is cleared on entering BUSY and incremented per transfer.
  - If a transfer occurs with count == MAX_BEATS-1 and out_last=0, the arbiter force-releases: next edge state<=IDLE, grant<=0, ptr<=sel+1, and err is pulsed high for exactly one cycle (registered).
  - The requester's remaining beats compete again as a new packet.
- Not defined: no counter is built; err is constant 0; packets of any length hold the grant.

Test Plan:
1. Reset, then req=16'h0000 for 5 cycles -> state IDLE, grant=0, out_valid=0, in_ready=0 throughout.
2. req=16'hFFFF, last=16'hFFFF, out_ready=1 held -> grants 0,1,2,...,15,0 in order, one beat every 2 cycles, out_data equals each requester's slice.
3. ptr=5 (after granting 4), req bits 2 and 9 set -> grant=bit 9, sel=9; the next arbitration with both still set grants 2.
4. Requester 3 sends a 4-beat packet; out_ready toggles 1,0,1,0,...; req[7] asserted throughout -> grant stays one-hot(3) until the 4th beat with last transfers, then one idle cycle, then grant=one-hot(7).
5. rst driven low mid-packet (beat 2 of 4, sel=6) -> next cycle grant=0, sel=0, ptr=0, out_valid=0. After release with req[6] and req[0] set, grant=one-hot(0).
6. With ARB16_MAXBEAT_EN and MAX_BEATS=4: requester 1 sends 6 beats, last only on beat 6 -> release after beat 4, err high for 1 cycle, re-grant to 1 after the idle cycle for beats 5-6. Without the macro: no release and err=0.

Source files
------------

// File: rtl/arb16_rr.sv
// arb16_rr: 16-requester round-robin packet arbiter sharing one W-bit output channel.
// Optional beat-limit forced release is built only when ARB16_MAXBEAT_EN is defined.

module arb16_rr_mux16 #(
  parameter int W = 32
) (
  input  logic [16*W-1:0] in_data,
  input  logic [3:0]      sel,
  output logic [W-1:0]    out_data
);

  logic [W-1:0] lvl0 [16];
  logic [W-1:0] lvl1 [8];
  logic [W-1:0] lvl2 [4];
  logic [W-1:0] lvl3 [2];

  for (genvar i = 0; i < 16; i++) begin : g_lvl0
    assign lvl0[i] = in_data[i*W +: W];
  end

  for (genvar i = 0; i < 8; i++) begin : g_lvl1
    assign lvl1[i] = sel[0] ? lvl0[2*i+1] : lvl0[2*i];
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl2
    assign lvl2[i] = sel[1] ? lvl1[2*i+1] : lvl1[2*i];
  end

  for (genvar i = 0; i < 2; i++) begin : g_lvl3
    assign lvl3[i] = sel[2] ? lvl2[2*i+1] : lvl2[2*i];
  end

  assign out_data = sel[3] ? lvl3[1] : lvl3[0];

endmodule

module arb16_rr #(
  parameter int W         = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     req,
  input  logic [15:0]     last,
  input  logic [16*W-1:0] in_data,
  output logic [15:0]     in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [15:0]     grant,
  output logic [3:0]      sel,
  output logic            err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // A beat limit below one is meaningless; this empty block names the constraint.
  if (MAX_BEATS < 1) begin : g_max_beats_must_be_positive
  end

  logic [0:0]  state_r;
  logic [0:0]  state_nxt_s;
  logic [3:0]  sel_r;
  logic [3:0]  sel_nxt_s;
  logic [3:0]  ptr_r;
  logic [3:0]  ptr_nxt_s;
  logic [15:0] grant_r;
  logic [15:0] grant_nxt_s;
  logic [3:0]  pick_s;
  logic        pick_vld_s;
  logic        busy_s;
  logic        valid_s;
  logic        last_s;
  logic        xfer_s;
  logic        force_s;
  logic        release_s;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  // Rotating-priority scan: walking offsets downward lets the smallest offset from ptr win.
  always_comb begin
    pick_s     = 4'd0;
    pick_vld_s = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (req[ptr_r + 4'(i)]) begin
        pick_s     = ptr_r + 4'(i);
        pick_vld_s = 1'b1;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  assign busy_s    = (state_r == BUSY);
  assign valid_s   = busy_s & req[sel_r];
  assign last_s    = valid_s & last[sel_r];
  assign xfer_s    = valid_s & out_ready;
  assign release_s = xfer_s & (last_s | force_s);

  arb16_rr_mux16 #(
    .W(W)
  ) u_mux (
    .in_data (in_data),
    .sel     (sel_r),
    .out_data(out_data)
  );

  // Next-state selection for the arbiter FSM and its grant registers.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    grant_nxt_s = grant_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s = BUSY;
          sel_nxt_s   = pick_s;
          grant_nxt_s = onehot16(pick_s);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (release_s) begin
          state_nxt_s = IDLE;
          grant_nxt_s = 16'd0;
          ptr_nxt_s   = sel_r + 4'd1;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = 16'd0;
      end
    endcase
  end

  // Arbiter state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      sel_r   <= 4'd0;
      ptr_r   <= 4'd0;
      grant_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      ptr_r   <= ptr_nxt_s;
      grant_r <= grant_nxt_s;
    end
  end

`ifdef ARB16_MAXBEAT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             err_r;

  assign force_s = xfer_s & ~last_s & (cnt_r == CNT_W'(MAX_BEATS - 1));

  // Beat counter restarts every time a grant is issued.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (state_r == IDLE) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (xfer_s) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Beat counter and one-cycle forced-release flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      err_r <= force_s;
    end
  end

  assign err = err_r;
`else
  assign force_s = 1'b0;
  assign err     = 1'b0;
`endif

  assign out_valid = valid_s;
  assign out_last  = last_s;
  assign in_ready  = grant_r & {16{out_ready}};
  assign grant     = grant_r;
  assign sel       = sel_r;

endmodule
